// File: rtl/cpu_pkg.sv
// Shared RV32I decode types: opcodes, control-word fields and small decode helpers.
package cpu_pkg;

  localparam int XLEN_DEF     = 32;
  localparam int NUM_REGS_DEF = 32;

  // Base opcodes (instr[6:0])
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_t;

  // Operand A uses REG/PC/ZERO, operand B uses REG/IMM
  typedef enum logic [1:0] {
    SRC_REG  = 2'd0,
    SRC_IMM  = 2'd1,
    SRC_PC   = 2'd2,
    SRC_ZERO = 2'd3
  } alu_src_t;

  typedef enum logic [2:0] {
    MEM_NONE = 3'd0,
    MEM_B    = 3'd1,
    MEM_H    = 3'd2,
    MEM_W    = 3'd3,
    MEM_BU   = 3'd4,
    MEM_HU   = 3'd5
  } mem_op_t;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_t;

  // br_funct3 carries the branch condition so EX can pick eq/ne/lt/ge from the ALU result
  typedef struct packed {
    alu_op_t     alu_op;
    alu_src_t    alu_src_a;
    alu_src_t    alu_src_b;
    mem_op_t     mem_ctrl;
    logic        mem_rd_en;
    logic        mem_wr_en;
    logic        reg_wr_en;
    wb_sel_t     wb_sel;
    logic        branch;
    logic        jump;
    logic        illegal;
    logic [2:0]  br_funct3;
  } id_ex_ctrl_t;

  localparam id_ex_ctrl_t CTRL_NOP = '{
    alu_op:    ALU_ADD,
    alu_src_a: SRC_REG,
    alu_src_b: SRC_REG,
    mem_ctrl:  MEM_NONE,
    mem_rd_en: 1'b0,
    mem_wr_en: 1'b0,
    reg_wr_en: 1'b0,
    wb_sel:    WB_ALU,
    branch:    1'b0,
    jump:      1'b0,
    illegal:   1'b0,
    br_funct3: 3'b000
  };

  function automatic logic [31:0] imm_i(input logic [31:0] ins);
    return {{20{ins[31]}}, ins[31:20]};
  endfunction

  function automatic logic [31:0] imm_s(input logic [31:0] ins);
    return {{20{ins[31]}}, ins[31:25], ins[11:7]};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] ins);
    return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_u(input logic [31:0] ins);
    return {ins[31:12], 12'h000};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] ins);
    return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
  endfunction

  // ALU op for OP / OP-IMM; alt is instr[30]. ADDI ignores alt since instr[30] is immediate there.
  function automatic alu_op_t alu_from_funct(input logic [2:0] f3, input logic alt,
                                             input logic is_imm);
    alu_op_t op;
    case (f3)
      3'b000:  op = (alt && !is_imm) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/decode_stage_reg_file.sv
// Architectural register file: 2 combinational read ports, 1 synchronous write port,
// x0 hard-wired to zero, same-cycle write data bypassed onto the read ports.
module reg_file
  import cpu_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic [AW-1:0]   i_rs1_addr,
  input  logic [AW-1:0]   i_rs2_addr,
  output logic [XLEN-1:0] o_rs1_data,
  output logic [XLEN-1:0] o_rs2_data,
  input  logic            i_wr_en,
  input  logic [AW-1:0]   i_wr_addr,
  input  logic [XLEN-1:0] i_wr_data
);

  logic [XLEN-1:0] r_regs [NUM_REGS];

  // Register storage: cleared on reset, written from writeback (x0 never written)
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= {XLEN{1'b0}};
      end
    end else if (i_wr_en && (i_wr_addr != {AW{1'b0}})) begin
      r_regs[i_wr_addr] <= i_wr_data;
    end
  end

  // Read port 1 with x0 forcing and write-through bypass
  always_comb begin
    if (i_rs1_addr == {AW{1'b0}}) begin
      o_rs1_data = {XLEN{1'b0}};
    end else if (i_wr_en && (i_wr_addr == i_rs1_addr)) begin
      o_rs1_data = i_wr_data;
    end else begin
      o_rs1_data = r_regs[i_rs1_addr];
    end
  end

  // Read port 2 with x0 forcing and write-through bypass
  always_comb begin
    if (i_rs2_addr == {AW{1'b0}}) begin
      o_rs2_data = {XLEN{1'b0}};
    end else if (i_wr_en && (i_wr_addr == i_rs2_addr)) begin
      o_rs2_data = i_wr_data;
    end else begin
      o_rs2_data = r_regs[i_rs2_addr];
    end
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: decoder, immediate generation, load-use hazard detection,
// register file and the ID/EX pipeline register.
module decode_stage
  import cpu_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [31:0]       i_instr_id,
  input  logic [31:0]       i_pc_id,
  input  logic [31:0]       i_pc_plus4_id,
  input  logic              i_valid_id,
  input  logic              i_flush,
  input  logic              i_wb_wr_en,
  input  logic [4:0]        i_wb_rd,
  input  logic [XLEN-1:0]   i_wb_data,
  output logic              o_stall_id,
  output logic              o_ex_valid,
  output logic [31:0]       o_ex_pc,
  output logic [31:0]       o_ex_pc_plus4,
  output logic [XLEN-1:0]   o_ex_rs1_data,
  output logic [XLEN-1:0]   o_ex_rs2_data,
  output logic [XLEN-1:0]   o_ex_imm,
  output logic [4:0]        o_ex_rs1,
  output logic [4:0]        o_ex_rs2,
  output logic [4:0]        o_ex_rd,
  output id_ex_ctrl_t       o_ex_ctrl
);

  // Instruction fields
  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic [6:0]      w_funct7;
  logic [4:0]      w_rs1;
  logic [4:0]      w_rs2;
  logic [4:0]      w_rd;

  // Decoder results
  id_ex_ctrl_t     w_ctrl;
  logic [XLEN-1:0] w_imm;
  logic            w_rs1_used;
  logic            w_rs2_used;
  logic            w_legal;
  logic [4:0]      w_rs1_addr;
  logic [4:0]      w_rs2_addr;
  logic [4:0]      w_rd_dec;
  logic [XLEN-1:0] w_rs1_data;
  logic [XLEN-1:0] w_rs2_data;
  logic            w_hazard;
  logic            w_stall;
  logic            w_bubble;

  // ID/EX register
  logic            r_ex_valid;
  logic [31:0]     r_ex_pc;
  logic [31:0]     r_ex_pc_plus4;
  logic [XLEN-1:0] r_ex_rs1_data;
  logic [XLEN-1:0] r_ex_rs2_data;
  logic [XLEN-1:0] r_ex_imm;
  logic [4:0]      r_ex_rs1;
  logic [4:0]      r_ex_rs2;
  logic [4:0]      r_ex_rd;
  id_ex_ctrl_t     r_ex_ctrl;

  assign w_opcode = i_instr_id[6:0];
  assign w_funct3 = i_instr_id[14:12];
  assign w_funct7 = i_instr_id[31:25];
  assign w_rs1    = i_instr_id[19:15];
  assign w_rs2    = i_instr_id[24:20];
  assign w_rd     = i_instr_id[11:7];

  // Unused source fields read x0 so EX never forwards against immediate bits
  assign w_rs1_addr = w_rs1_used ? w_rs1 : 5'd0;
  assign w_rs2_addr = w_rs2_used ? w_rs2 : 5'd0;
  assign w_rd_dec   = w_ctrl.reg_wr_en ? w_rd : 5'd0;

  reg_file #(
    .XLEN     (XLEN),
    .NUM_REGS (NUM_REGS)
  ) u_reg_file (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_rs1_addr (w_rs1_addr),
    .i_rs2_addr (w_rs2_addr),
    .o_rs1_data (w_rs1_data),
    .o_rs2_data (w_rs2_data),
    .i_wr_en    (i_wb_wr_en),
    .i_wr_addr  (i_wb_rd),
    .i_wr_data  (i_wb_data)
  );

  // Main decoder: control word, immediate, source usage and legality
  always_comb begin
    w_ctrl     = CTRL_NOP;
    w_imm      = {XLEN{1'b0}};
    w_rs1_used = 1'b0;
    w_rs2_used = 1'b0;
    w_legal    = 1'b0;
    case (w_opcode)
      OP_LUI: begin
        w_legal            = 1'b1;
        w_ctrl.alu_src_a   = SRC_ZERO;
        w_ctrl.alu_src_b   = SRC_IMM;
        w_ctrl.reg_wr_en   = 1'b1;
        w_imm              = imm_u(i_instr_id);
      end
      OP_AUIPC: begin
        w_legal            = 1'b1;
        w_ctrl.alu_src_a   = SRC_PC;
        w_ctrl.alu_src_b   = SRC_IMM;
        w_ctrl.reg_wr_en   = 1'b1;
        w_imm              = imm_u(i_instr_id);
      end
      OP_JAL: begin
        w_legal            = 1'b1;
        w_ctrl.alu_src_a   = SRC_PC;
        w_ctrl.alu_src_b   = SRC_IMM;
        w_ctrl.reg_wr_en   = 1'b1;
        w_ctrl.wb_sel      = WB_PC4;
        w_ctrl.jump        = 1'b1;
        w_imm              = imm_j(i_instr_id);
      end
      OP_JALR: begin
        w_legal            = (w_funct3 == 3'b000);
        w_ctrl.alu_src_b   = SRC_IMM;
        w_ctrl.reg_wr_en   = 1'b1;
        w_ctrl.wb_sel      = WB_PC4;
        w_ctrl.jump        = 1'b1;
        w_rs1_used         = 1'b1;
        w_imm              = imm_i(i_instr_id);
      end
      OP_BRANCH: begin
        w_legal            = (w_funct3 != 3'b010) && (w_funct3 != 3'b011);
        w_ctrl.branch      = 1'b1;
        w_ctrl.br_funct3   = w_funct3;
        w_rs1_used         = 1'b1;
        w_rs2_used         = 1'b1;
        w_imm              = imm_b(i_instr_id);
        case (w_funct3)
          3'b000, 3'b001: w_ctrl.alu_op = ALU_SUB;
          3'b100, 3'b101: w_ctrl.alu_op = ALU_SLT;
          3'b110, 3'b111: w_ctrl.alu_op = ALU_SLTU;
          default:        w_ctrl.alu_op = ALU_ADD;
        endcase
      end
      OP_LOAD: begin
        w_legal            = 1'b1;
        w_ctrl.alu_src_b   = SRC_IMM;
        w_ctrl.mem_rd_en   = 1'b1;
        w_ctrl.reg_wr_en   = 1'b1;
        w_ctrl.wb_sel      = WB_MEM;
        w_rs1_used         = 1'b1;
        w_imm              = imm_i(i_instr_id);
        case (w_funct3)
          3'b000:  w_ctrl.mem_ctrl = MEM_B;
          3'b001:  w_ctrl.mem_ctrl = MEM_H;
          3'b010:  w_ctrl.mem_ctrl = MEM_W;
          3'b100:  w_ctrl.mem_ctrl = MEM_BU;
          3'b101:  w_ctrl.mem_ctrl = MEM_HU;
          default: w_legal         = 1'b0;
        endcase
      end
      OP_STORE: begin
        w_legal            = 1'b1;
        w_ctrl.alu_src_b   = SRC_IMM;
        w_ctrl.mem_wr_en   = 1'b1;
        w_rs1_used         = 1'b1;
        w_rs2_used         = 1'b1;
        w_imm              = imm_s(i_instr_id);
        case (w_funct3)
          3'b000:  w_ctrl.mem_ctrl = MEM_B;
          3'b001:  w_ctrl.mem_ctrl = MEM_H;
          3'b010:  w_ctrl.mem_ctrl = MEM_W;
          default: w_legal         = 1'b0;
        endcase
      end
      OP_IMM: begin
        w_ctrl.alu_op      = alu_from_funct(w_funct3, i_instr_id[30], 1'b1);
        w_ctrl.alu_src_b   = SRC_IMM;
        w_ctrl.reg_wr_en   = 1'b1;
        w_rs1_used         = 1'b1;
        w_imm              = imm_i(i_instr_id);
        case (w_funct3)
          3'b001:  w_legal = (w_funct7 == 7'h00);
          3'b101:  w_legal = (w_funct7 == 7'h00) || (w_funct7 == 7'h20);
          default: w_legal = 1'b1;
        endcase
      end
      OP_OP: begin
        w_legal            = (w_funct7 == 7'h00) ||
                             ((w_funct7 == 7'h20) &&
                              ((w_funct3 == 3'b000) || (w_funct3 == 3'b101)));
        w_ctrl.alu_op      = alu_from_funct(w_funct3, w_funct7[5], 1'b0);
        w_ctrl.reg_wr_en   = 1'b1;
        w_rs1_used         = 1'b1;
        w_rs2_used         = 1'b1;
      end
      OP_FENCE, OP_SYSTEM: begin
        // No pipeline side effects in this core: issue as a valid NOP
        w_legal = 1'b1;
      end
      default: begin
        w_legal = 1'b0;
      end
    endcase
    if (w_legal) begin
      w_ctrl.illegal = 1'b0;
    end else begin
      w_ctrl         = CTRL_NOP;
      w_ctrl.illegal = 1'b1;
      w_imm          = {XLEN{1'b0}};
      w_rs1_used     = 1'b0;
      w_rs2_used     = 1'b0;
    end
  end

  // Load-use hazard: the load in EX targets a register this instruction actually reads
  always_comb begin
    if (i_valid_id && r_ex_valid && r_ex_ctrl.mem_rd_en && (r_ex_rd != 5'd0)) begin
      w_hazard = (w_rs1_used && (r_ex_rd == w_rs1)) || (w_rs2_used && (r_ex_rd == w_rs2));
    end else begin
      w_hazard = 1'b0;
    end
  end

  assign w_stall    = w_hazard && !i_flush;
  assign w_bubble   = i_reset || i_flush || w_stall || !i_valid_id;
  assign o_stall_id = w_stall;

  // ID/EX register: reset, flush, stall and empty IF/ID all load a bubble
  always_ff @(posedge i_clk) begin
    if (w_bubble) begin
      r_ex_valid    <= 1'b0;
      r_ex_pc       <= 32'h0000_0000;
      r_ex_pc_plus4 <= 32'h0000_0000;
      r_ex_rs1_data <= {XLEN{1'b0}};
      r_ex_rs2_data <= {XLEN{1'b0}};
      r_ex_imm      <= {XLEN{1'b0}};
      r_ex_rs1      <= 5'd0;
      r_ex_rs2      <= 5'd0;
      r_ex_rd       <= 5'd0;
      r_ex_ctrl     <= CTRL_NOP;
    end else begin
      r_ex_valid    <= 1'b1;
      r_ex_pc       <= i_pc_id;
      r_ex_pc_plus4 <= i_pc_plus4_id;
      r_ex_rs1_data <= w_rs1_data;
      r_ex_rs2_data <= w_rs2_data;
      r_ex_imm      <= w_imm;
      r_ex_rs1      <= w_rs1_addr;
      r_ex_rs2      <= w_rs2_addr;
      r_ex_rd       <= w_rd_dec;
      r_ex_ctrl     <= w_ctrl;
    end
  end

  assign o_ex_valid    = r_ex_valid;
  assign o_ex_pc       = r_ex_pc;
  assign o_ex_pc_plus4 = r_ex_pc_plus4;
  assign o_ex_rs1_data = r_ex_rs1_data;
  assign o_ex_rs2_data = r_ex_rs2_data;
  assign o_ex_imm      = r_ex_imm;
  assign o_ex_rs1      = r_ex_rs1;
  assign o_ex_rs2      = r_ex_rs2;
  assign o_ex_rd       = r_ex_rd;
  assign o_ex_ctrl     = r_ex_ctrl;

endmodule
